// File: rtl/pn_sched_ctrl.sv
// pn_sched_ctrl: configures, sequences and drains a bank of soma instances.
// It holds per-neuron config words, loads them over a shared W_DATA bus,
// broadcasts the timestep interval, and serialises rising-edge spike events
// into an output FIFO through a round-robin arbiter.
module pn_sched_ctrl #(
    parameter int NUM_PN     = 4,
    parameter int IDW        = $clog2(NUM_PN),
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [IDW-1:0]       cfg_addr,
    input  logic [31:0]          cfg_data,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 abort,
    input  logic                 tick,
    input  logic [15:0]          step_interval,
    output logic [31:0]          pn_wdata,
    output logic [NUM_PN-1:0]    pn_cfg_sel,
    output logic [NUM_PN-1:0]    pn_en,
    output logic [NUM_PN-1:0]    pn_kill,
    input  logic [16*NUM_PN-1:0] pn_spike,
    output logic                 spk_valid,
    input  logic                 spk_ready,
    output logic [IDW-1:0]       spk_id,
    output logic [15:0]          spk_delay,
    output logic                 overflow,
    output logic                 busy
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [31:0]         cfg_mem [NUM_PN];
    logic [NUM_PN-1:0]   cfg_vld;
    logic [IDW-1:0]      idx;
    logic [15:0]         interval_q;
    logic [NUM_PN-1:0]   kill_q;
    logic [15:0]         spike_prev [NUM_PN];
    logic [NUM_PN-1:0]   pend;
    logic [15:0]         pend_delay [NUM_PN];
    logic [IDW-1:0]      rr_ptr;
    logic                overflow_q;
    logic [IDW+15:0]     fifo_mem [FIFO_DEPTH];
    logic [IDW+15:0]     fifo_head;
    logic [PW:0]         wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, push, pop, cfg_wr;
    logic [NUM_PN-1:0]   event_v;
    logic                gnt_vld;
    logic [IDW-1:0]      gnt_idx;
    int                  cand;

    assign cfg_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign cfg_wr     = cfg_valid & cfg_ready;
    assign pn_kill    = kill_q;
    assign overflow   = overflow_q;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign spk_valid  = ~fifo_empty;
    assign pop        = spk_valid & spk_ready;
    assign push       = gnt_vld & (~fifo_full | pop) & ~abort;
    assign fifo_head  = fifo_mem[rd_ptr[PW-1:0]];
    assign spk_id     = fifo_head[IDW+15:16];
    assign spk_delay  = fifo_head[15:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; abort wins over every other request
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start && (cfg_vld != '0 || cfg_wr)) state_d = S_LOAD;
                S_LOAD:  if (idx == IDW'(NUM_PN - 1)) state_d = S_RUN;
                S_RUN:   if (stop) state_d = S_DRAIN;
                S_DRAIN: if (pend == '0 && fifo_empty) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Soma-facing outputs decoded from registered state
    always_comb begin
        pn_wdata   = 32'h0;
        pn_cfg_sel = '0;
        pn_en      = '0;
        case (state_q)
            S_LOAD: begin
                pn_wdata   = cfg_mem[idx];
                pn_cfg_sel = cfg_vld & (NUM_PN'(1) << idx);
            end
            S_RUN: begin
                pn_wdata = {16'h0, interval_q};
                pn_en    = cfg_vld;
            end
            default: ;
        endcase
    end

    // Configuration storage, only writable while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_vld <= '0;
            for (int i = 0; i < NUM_PN; i++) cfg_mem[i] <= 32'h0;
        end else if (cfg_wr) begin
            cfg_mem[cfg_addr] <= cfg_data;
            cfg_vld[cfg_addr] <= 1'b1;
        end
    end

    // Load index, latched interval and the one-cycle kill pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= '0;
            interval_q <= 16'h0;
            kill_q     <= '0;
        end else begin
            idx <= (state_q == S_LOAD && state_d == S_LOAD) ? idx + 1'b1 : '0;
            if (tick) interval_q <= step_interval;
            if (abort)                         kill_q <= '1;
            else if (state_q == S_RUN && stop) kill_q <= cfg_vld;
            else                               kill_q <= '0;
        end
    end

    // Previous-cycle spike values for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PN; i++) spike_prev[i] <= 16'h0;
        end else begin
            for (int i = 0; i < NUM_PN; i++) spike_prev[i] <= pn_spike[16*i +: 16];
        end
    end

    // Rising-edge events from enabled somas while running or draining
    always_comb begin
        event_v = '0;
        for (int i = 0; i < NUM_PN; i++) begin
            event_v[i] = (state_q == S_RUN || state_q == S_DRAIN) && pn_en[i] &&
                         (pn_spike[16*i +: 16] != 16'h0) && (spike_prev[i] == 16'h0);
        end
    end

    // Round-robin pick of the first pending neuron at or after rr_ptr
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_PN; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_PN;
            if (!gnt_vld && pend[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'(cand);
            end
        end
    end

    // Pending-event slots; a granted slot can be refilled in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend       <= '0;
            rr_ptr     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NUM_PN; i++) pend_delay[i] <= 16'h0;
        end else if (abort) begin
            pend <= '0;
        end else begin
            if (push) rr_ptr <= (gnt_idx == IDW'(NUM_PN - 1)) ? '0 : gnt_idx + 1'b1;
            for (int i = 0; i < NUM_PN; i++) begin
                if (event_v[i]) begin
                    if (pend[i] && !(push && gnt_idx == IDW'(i))) begin
                        overflow_q <= 1'b1;
                    end else begin
                        pend[i]       <= 1'b1;
                        pend_delay[i] <= pn_spike[16*i +: 16];
                    end
                end else if (push && gnt_idx == IDW'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // FIFO storage array
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= {gnt_idx, pend_delay[gnt_idx]};
    end

    // FIFO pointers, flushed on abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_pn_sched_ctrl.sv
// tb_pn_sched_ctrl: directed bench for pn_sched_ctrl with hand-computed
// expectations checked by immediate assertions.
module tb_pn_sched_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        start, stop, abort, tick;
    logic [15:0] step_interval;
    logic [31:0] pn_wdata;
    logic [3:0]  pn_cfg_sel, pn_en, pn_kill;
    logic [63:0] pn_spike;
    logic        spk_valid, spk_ready;
    logic [1:0]  spk_id;
    logic [15:0] spk_delay;
    logic        overflow, busy;

    int n_checks = 0;
    int n_fail   = 0;

    pn_sched_ctrl #(.NUM_PN(4), .IDW(2), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .stop(stop), .abort(abort), .tick(tick), .step_interval(step_interval),
        .pn_wdata(pn_wdata), .pn_cfg_sel(pn_cfg_sel), .pn_en(pn_en), .pn_kill(pn_kill),
        .pn_spike(pn_spike), .spk_valid(spk_valid), .spk_ready(spk_ready),
        .spk_id(spk_id), .spk_delay(spk_delay), .overflow(overflow), .busy(busy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold current inputs for n rising edges, then settle just past the edge
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One comparison against a hand-computed value
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Directed sequence
    initial begin
        rst = 1'b0; cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = 32'h0;
        start = 1'b0; stop = 1'b0; abort = 1'b0; tick = 1'b0; step_interval = 16'h0;
        pn_spike = 64'h0; spk_ready = 1'b0;
        #3;
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'h1);
        checkOutput("rst_busy",      32'(busy),      32'h0);
        checkOutput("rst_spk_valid", 32'(spk_valid), 32'h0);
        checkOutput("rst_overflow",  32'(overflow),  32'h0);
        checkOutput("rst_pn_en",     32'(pn_en),     32'h0);
        checkOutput("rst_pn_kill",   32'(pn_kill),   32'h0);
        checkOutput("rst_cfg_sel",   32'(pn_cfg_sel), 32'h0);
        checkOutput("rst_wdata",     pn_wdata,       32'h0);
        applyStimulus(1);
        rst = 1'b1;

        $display("[TB] config neurons 0 and 2, start together with the last write");
        cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 32'h14020305;
        applyStimulus(1);
        cfg_addr = 2'd2; cfg_data = 32'h20010408; start = 1'b1;
        applyStimulus(1);
        cfg_valid = 1'b0; start = 1'b0;
        checkOutput("load0_sel",   32'(pn_cfg_sel), 32'h1);
        checkOutput("load0_wdata", pn_wdata,        32'h14020305);
        checkOutput("load0_ready", 32'(cfg_ready),  32'h0);
        applyStimulus(1);
        checkOutput("load1_sel",   32'(pn_cfg_sel), 32'h0);
        applyStimulus(1);
        checkOutput("load2_sel",   32'(pn_cfg_sel), 32'h4);
        checkOutput("load2_wdata", pn_wdata,        32'h20010408);
        applyStimulus(1);
        checkOutput("load3_sel",   32'(pn_cfg_sel), 32'h0);
        applyStimulus(1);
        checkOutput("run_en_0101", 32'(pn_en),      32'h5);

        $display("[TB] tick broadcast");
        tick = 1'b1; step_interval = 16'h0007;
        applyStimulus(1);
        tick = 1'b0; step_interval = 16'h0;
        checkOutput("tick_wdata", pn_wdata, 32'h00000007);

        $display("[TB] stop with empty queue, then configure neurons 1 and 3");
        stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("stop1_kill", 32'(pn_kill), 32'h5);
        checkOutput("stop1_en",   32'(pn_en),   32'h0);
        applyStimulus(1);
        checkOutput("stop1_idle", 32'(busy),    32'h0);
        checkOutput("stop1_kill_off", 32'(pn_kill), 32'h0);
        cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = 32'h11111111;
        applyStimulus(1);
        cfg_addr = 2'd3; cfg_data = 32'h33333333;
        applyStimulus(1);
        cfg_valid = 1'b0; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(4);
        checkOutput("run_en_1111", 32'(pn_en), 32'hF);

        $display("[TB] simultaneous spikes on all somas");
        spk_ready = 1'b1;
        pn_spike = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        applyStimulus(1);
        pn_spike = 64'h0;
        checkOutput("sim_t1_valid", 32'(spk_valid), 32'h0);
        applyStimulus(1);
        checkOutput("sim_id0",  32'(spk_id),    32'h0);
        checkOutput("sim_dl0",  32'(spk_delay), 32'h11);
        applyStimulus(1);
        checkOutput("sim_id1",  32'(spk_id),    32'h1);
        checkOutput("sim_dl1",  32'(spk_delay), 32'h22);
        applyStimulus(1);
        checkOutput("sim_id2",  32'(spk_id),    32'h2);
        checkOutput("sim_dl2",  32'(spk_delay), 32'h33);
        applyStimulus(1);
        checkOutput("sim_id3",  32'(spk_id),    32'h3);
        checkOutput("sim_dl3",  32'(spk_delay), 32'h44);
        applyStimulus(1);
        checkOutput("sim_empty", 32'(spk_valid), 32'h0);
        checkOutput("sim_rr_ptr", 32'(dut.rr_ptr), 32'h0);

        $display("[TB] backpressure: ten events on neuron 1");
        spk_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            pn_spike = 64'(k) << 16;
            applyStimulus(1);
            pn_spike = 64'h0;
            applyStimulus(1);
            if (k == 9) checkOutput("bp_no_ovf_yet", 32'(overflow), 32'h0);
        end
        checkOutput("bp_overflow", 32'(overflow),  32'h1);
        checkOutput("bp_valid",    32'(spk_valid), 32'h1);
        checkOutput("bp_head_id",  32'(spk_id),    32'h1);
        checkOutput("bp_head_dl",  32'(spk_delay), 32'h1);

        $display("[TB] pop six entries, pending ninth event refills");
        spk_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            checkOutput("pop6_dl", 32'(spk_delay), 32'(j + 1));
            applyStimulus(1);
        end
        spk_ready = 1'b0;
        checkOutput("q3_head", 32'(spk_delay), 32'h7);

        $display("[TB] stop with three queued entries");
        stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("drain_kill", 32'(pn_kill), 32'hF);
        checkOutput("drain_en",   32'(pn_en),   32'h0);
        checkOutput("drain_busy", 32'(busy),    32'h1);
        applyStimulus(1);
        checkOutput("drain_kill_off", 32'(pn_kill), 32'h0);
        checkOutput("drain_busy2",    32'(busy),    32'h1);
        spk_ready = 1'b1;
        checkOutput("drain_dl7", 32'(spk_delay), 32'h7);
        applyStimulus(1);
        checkOutput("drain_dl8", 32'(spk_delay), 32'h8);
        checkOutput("drain_busy3", 32'(busy), 32'h1);
        applyStimulus(1);
        checkOutput("drain_dl9", 32'(spk_delay), 32'h9);
        checkOutput("drain_busy4", 32'(busy), 32'h1);
        applyStimulus(1);
        spk_ready = 1'b0;
        checkOutput("drain_empty", 32'(spk_valid), 32'h0);
        applyStimulus(1);
        checkOutput("drain_idle", 32'(busy), 32'h0);

        $display("[TB] abort in the middle of LOAD");
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("ab_load0_sel",   32'(pn_cfg_sel), 32'h1);
        checkOutput("ab_load0_wdata", pn_wdata,        32'h14020305);
        applyStimulus(1);
        checkOutput("ab_load1_sel",   32'(pn_cfg_sel), 32'h2);
        abort = 1'b1;
        applyStimulus(1);
        abort = 1'b0;
        checkOutput("ab_kill",  32'(pn_kill),   32'hF);
        checkOutput("ab_busy",  32'(busy),      32'h0);
        checkOutput("ab_ready", 32'(cfg_ready), 32'h1);
        applyStimulus(1);
        checkOutput("ab_kill_off", 32'(pn_kill), 32'h0);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("ab_restart_sel", 32'(pn_cfg_sel), 32'h1);
        applyStimulus(4);
        checkOutput("ab_run_en", 32'(pn_en), 32'hF);

        $display("[TB] asynchronous reset mid-run");
        #2 rst = 1'b0;
        #1;
        checkOutput("ar_busy",     32'(busy),       32'h0);
        checkOutput("ar_ready",    32'(cfg_ready),  32'h1);
        checkOutput("ar_en",       32'(pn_en),      32'h0);
        checkOutput("ar_wdata",    pn_wdata,        32'h0);
        checkOutput("ar_overflow", 32'(overflow),   32'h0);
        checkOutput("ar_kill",     32'(pn_kill),    32'h0);
        checkOutput("ar_cfg_vld",  32'(dut.cfg_vld), 32'h0);
        applyStimulus(1);
        rst = 1'b1;
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("ar_start_ignored", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
